// File: rtl/elevator_call_register_if.sv
// Call-register bus: raw buttons and lift status in, pending requests and stuck flags out.
interface elevator_call_register_if #(
  parameter int unsigned NUM_FLOORS = 3
);
  logic [NUM_FLOORS-1:0] btn;
  logic [1:0]            current_floor;
  logic                  door_open;
  logic                  moving;
  logic [NUM_FLOORS-1:0] req;
  logic                  any_req;
  logic [NUM_FLOORS-1:0] btn_stuck;

  modport master (
    output btn, current_floor, door_open, moving,
    input  req, any_req, btn_stuck
  );

  modport slave (
    input  btn, current_floor, door_open, moving,
    output req, any_req, btn_stuck
  );
endinterface

// File: rtl/elevator_call_register.sv
// Per-floor call register: 2-FF synchroniser, debounce, press latching,
// service clear and stuck-button reporting.
module elevator_call_register #(
  parameter int unsigned NUM_FLOORS      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  elevator_call_register_if.slave    bus
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned STW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STW-1:0] ST_MAX  = STW'(STUCK_CYCLES);

  logic [NUM_FLOORS-1:0] sync1_q, sync2_q;
  logic [NUM_FLOORS-1:0] stable_q, stable_d;
  logic [DBW-1:0]        db_cnt_q    [NUM_FLOORS];
  logic [DBW-1:0]        db_cnt_d    [NUM_FLOORS];
  logic [STW-1:0]        stuck_cnt_q [NUM_FLOORS];
  logic [STW-1:0]        stuck_cnt_d [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] stuck_q, stuck_d;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic                  any_req_q, any_req_d;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] service;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, press detection, stuck detection and request update
  always_comb begin
    stable_d  = stable_q;
    stuck_d   = stuck_q;
    req_d     = req_q;
    press     = '0;
    service   = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      db_cnt_d[i]    = '0;
      stuck_cnt_d[i] = stuck_cnt_q[i];

      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press[i]    = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end

      // Stuck counter looks at the level held before this edge
      if (stable_q[i]) begin
        if (stuck_cnt_q[i] != ST_MAX) begin
          stuck_cnt_d[i] = stuck_cnt_q[i] + STW'(1);
        end
        stuck_d[i] = stuck_q[i] | (stuck_cnt_d[i] == ST_MAX);
      end else begin
        stuck_cnt_d[i] = '0;
        stuck_d[i]     = 1'b0;
      end

      // Clear takes priority so a press at the open door is absorbed
      service[i] = bus.door_open && !bus.moving &&
                   ({30'd0, bus.current_floor} == i);
      if (service[i]) begin
        req_d[i] = 1'b0;
      end else if (press[i]) begin
        req_d[i] = 1'b1;
      end
    end
    any_req_d = |req_d;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q  <= '0;
      stuck_q   <= '0;
      req_q     <= '0;
      any_req_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
        db_cnt_q[i]    <= '0;
        stuck_cnt_q[i] <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      stuck_q   <= stuck_d;
      req_q     <= req_d;
      any_req_q <= any_req_d;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
        db_cnt_q[i]    <= db_cnt_d[i];
        stuck_cnt_q[i] <= stuck_cnt_d[i];
      end
    end
  end

  assign bus.req       = req_q;
  assign bus.any_req   = any_req_q;
  assign bus.btn_stuck = stuck_q;

endmodule

// File: tb/tb_elevator_call_register.sv
// Bench for elevator_call_register: directed scenarios plus randomized
// traffic, all checked against a sample-window reference model.
module tb_elevator_call_register;

  localparam int NF = 3;
  localparam int DB = 4;
  localparam int ST = 20;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  elevator_call_register_if #(.NUM_FLOORS(NF)) bus_if ();

  elevator_call_register #(
    .NUM_FLOORS     (NF),
    .DEBOUNCE_CYCLES(DB),
    .STUCK_CYCLES   (ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  // Reference model: a button's stable level flips once the last DB
  // synchronised samples all disagree with it; samples reach the debouncer
  // two edges after being taken. hist[0] is btn at the previous edge.
  logic [NF-1:0] hist [0:DB];
  logic [NF-1:0] m_stable, m_req, m_stuck;
  int            m_run [NF];

  task automatic model_clear();
    for (int j = 0; j <= DB; j++) hist[j] = '0;
    m_stable = '0;
    m_req    = '0;
    m_stuck  = '0;
    for (int i = 0; i < NF; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NF-1:0] ns;
    logic          flip;
    if (!reset) begin
      model_clear();
      return;
    end
    ns = m_stable;
    for (int i = 0; i < NF; i++) begin
      flip = 1'b1;
      for (int j = 1; j <= DB; j++)
        if (hist[j][i] == m_stable[i]) flip = 1'b0;
      if (flip) ns[i] = ~m_stable[i];
      if (m_stable[i]) begin
        m_run[i]   = (m_run[i] + 1 > ST) ? ST : m_run[i] + 1;
        m_stuck[i] = (m_run[i] >= ST);
      end else begin
        m_run[i]   = 0;
        m_stuck[i] = 1'b0;
      end
      if (bus_if.door_open && !bus_if.moving && int'(bus_if.current_floor) == i)
        m_req[i] = 1'b0;
      else if (flip && ns[i])
        m_req[i] = 1'b1;
    end
    m_stable = ns;
    for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = bus_if.btn;
  endtask

  function automatic logic [2*NF:0] model_vec();
    return {m_req, |m_req, m_stuck};
  endfunction

  // One clock: model follows the active edge, outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_if.btn = 3'b111;
    bus_if.current_floor = 2'd0;
    bus_if.door_open = 1'b0;
    bus_if.moving = 1'b0;
    model_clear();
    #2;
    vectors++;
    if ({bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_async: got req=%b any=%b stuck=%b, want all 0",
               bus_if.req, bus_if.any_req, bus_if.btn_stuck);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_hold: got %b, want %b",
                 {bus_if.req, bus_if.any_req, bus_if.btn_stuck}, model_vec());
      end
    end
    reset = 1'b1;
    bus_if.btn = 3'b000;
  endtask

  task automatic test_latency();
    bus_if.btn = 3'b010;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if ({bus_if.req, bus_if.any_req} !== ((e >= 6) ? 4'b0101 : 4'b0000)) begin
        miscompares++;
        $display("FAIL latency edge %0d: got req=%b any=%b, want req=%b",
                 e, bus_if.req, bus_if.any_req, (e >= 6) ? 3'b010 : 3'b000);
      end
      vectors++;
      if ({bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
        miscompares++;
        $display("FAIL latency_model edge %0d: got %b, want %b", e,
                 {bus_if.req, bus_if.any_req, bus_if.btn_stuck}, model_vec());
      end
    end
    bus_if.btn = 3'b000;
    for (int k = 0; k < 10; k++) tick();
    vectors++;
    if (bus_if.req !== 3'b010) begin
      miscompares++;
      $display("FAIL release_keeps_req: got %b, want 010", bus_if.req);
    end
  endtask

  task automatic test_glitch();
    bus_if.btn = 3'b100;
    for (int k = 0; k < 3; k++) tick();
    bus_if.btn = 3'b000;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (bus_if.req !== 3'b010 || bus_if.req !== m_req) begin
        miscompares++;
        $display("FAIL glitch: got req=%b, want 010 (model %b)", bus_if.req, m_req);
      end
    end
  endtask

  task automatic test_service();
    bus_if.btn = 3'b100;
    for (int k = 0; k < 8; k++) tick();
    bus_if.btn = 3'b000;
    for (int k = 0; k < 10; k++) tick();
    vectors++;
    if (bus_if.req !== 3'b110) begin
      miscompares++;
      $display("FAIL setup_110: got %b, want 110", bus_if.req);
    end
    bus_if.current_floor = 2'd1;
    bus_if.door_open = 1'b1;
    bus_if.moving = 1'b1;
    tick();
    vectors++;
    if (bus_if.req !== 3'b110) begin
      miscompares++;
      $display("FAIL moving_no_clear: got %b, want 110", bus_if.req);
    end
    bus_if.moving = 1'b0;
    tick();
    vectors++;
    if ({bus_if.req, bus_if.any_req} !== 4'b1001) begin
      miscompares++;
      $display("FAIL service_clear: got req=%b any=%b, want req=100 any=1",
               bus_if.req, bus_if.any_req);
    end
    bus_if.current_floor = 2'd3;
    for (int k = 0; k < 3; k++) tick();
    vectors++;
    if (bus_if.req !== 3'b100 || bus_if.req !== m_req) begin
      miscompares++;
      $display("FAIL floor3_no_clear: got %b, want 100 (model %b)", bus_if.req, m_req);
    end
    bus_if.door_open = 1'b0;
  endtask

  task automatic test_press_at_service();
    bus_if.current_floor = 2'd2;
    bus_if.door_open = 1'b1;
    bus_if.moving = 1'b0;
    bus_if.btn = 3'b101;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if ({bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
        miscompares++;
        $display("FAIL absorb_model cycle %0d: got %b, want %b", k,
                 {bus_if.req, bus_if.any_req, bus_if.btn_stuck}, model_vec());
      end
    end
    vectors++;
    if (bus_if.req !== 3'b001) begin
      miscompares++;
      $display("FAIL press_absorbed: got %b, want 001", bus_if.req);
    end
    bus_if.btn = 3'b000;
    bus_if.door_open = 1'b0;
    bus_if.current_floor = 2'd1;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_stuck();
    bus_if.btn = 3'b001;
    for (int e = 1; e <= 40; e++) begin
      tick();
      vectors++;
      if (bus_if.btn_stuck !== ((e >= 6 + ST) ? 3'b001 : 3'b000) ||
          {bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
        miscompares++;
        $display("FAIL stuck edge %0d: got stuck=%b req=%b, want stuck=%b (model %b)",
                 e, bus_if.btn_stuck, bus_if.req,
                 (e >= 6 + ST) ? 3'b001 : 3'b000, model_vec());
      end
    end
    bus_if.btn = 3'b000;
    for (int k = 0; k < 10; k++) tick();
    vectors++;
    if (bus_if.btn_stuck !== 3'b000) begin
      miscompares++;
      $display("FAIL stuck_release: got %b, want 000", bus_if.btn_stuck);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(4) == 0)
        bus_if.btn[$urandom_range(NF - 1)] = ~bus_if.btn[$urandom_range(NF - 1)];
      if ($urandom_range(3) == 0) begin
        bus_if.current_floor = 2'($urandom_range(3));
        bus_if.door_open     = 1'($urandom_range(1));
        bus_if.moving        = ($urandom_range(3) == 0);
      end
      tick();
      vectors++;
      if ({bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b, want %b", k,
                 {bus_if.req, bus_if.any_req, bus_if.btn_stuck}, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    bus_if.btn = 3'b010;
    bus_if.current_floor = 2'd0;
    bus_if.door_open = 1'b0;
    bus_if.moving = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    vectors++;
    if (bus_if.req[1] !== 1'b1 || {bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
      miscompares++;
      $display("FAIL pre_reset: got req=%b, want req[1]=1 (model %b)", bus_if.req, m_req);
    end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if ({bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got req=%b any=%b stuck=%b, want all 0",
               bus_if.req, bus_if.any_req, bus_if.btn_stuck);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (bus_if.req[1] !== (e >= 6) ||
          {bus_if.req, bus_if.any_req, bus_if.btn_stuck} !== model_vec()) begin
        miscompares++;
        $display("FAIL reregister edge %0d: got req=%b, want req[1]=%0d (model %b)",
                 e, bus_if.req, (e >= 6), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_service();
    test_press_at_service();
    test_stuck();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
